id_ex_issue: RTL

- Decode-and-issue stage that produces the operands and ALUop consumed by the 16-bit execute ALU.
- Decodes one 16-bit instruction per cycle and reads the register file combinationally.
- Selects the ALU operands and registers them, with control, into the ID/EX pipeline register.
- Also performs load-use hazard detection, downstream hold, and branch flush.

---
 rtl/id_ex_issue.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/id_ex_issue.sv
// Decode-and-issue stage: decodes one instruction per cycle, reads the register file,
// detects load-use hazards and registers ALU operands plus control into the ID/EX register.
module id_ex_issue #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [15:0]       if_instr,
  input  logic              flush,
  input  logic              ex_hold,
  output logic [REG_AW-1:0] rf_raddr1,
  output logic [REG_AW-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [1:0]        ex_aluop,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic              ex_illegal
);

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ANDI = 4'b0001;
  localparam logic [3:0] OP_ADDI = 4'b0010;
  localparam logic [3:0] OP_LW   = 4'b0011;
  localparam logic [3:0] OP_SW   = 4'b0100;
  localparam logic [3:0] OP_BEQ  = 4'b0101;
  localparam logic [3:0] OP_NOP  = 4'b0110;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;

  logic [3:0]        op;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic [2:0]        func;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] rd1, rd2;

  assign op      = if_instr[15:12];
  assign rd      = if_instr[11:9];
  assign rs1     = if_instr[8:6];
  assign rs2     = if_instr[5:3];
  assign func    = if_instr[2:0];
  assign imm_ext = {{(DATA_W-6){if_instr[5]}}, if_instr[5:0]};

  // SW and BEQ need R[rd] as their second operand, so port 2 is steered to rd for them.
  assign rf_raddr1 = rs1;
  assign rf_raddr2 = (op == OP_SW || op == OP_BEQ) ? rd : rs2;
  assign rd1 = (rf_raddr1 == '0) ? '0 : rf_rdata1;
  assign rd2 = (rf_raddr2 == '0) ? '0 : rf_rdata2;

  logic              dec_legal;
  logic [1:0]        dec_aluop;
  logic [DATA_W-1:0] dec_a, dec_b, dec_store;
  logic              dec_rw, dec_mr, dec_mw, dec_br;
  logic              use_rs1, use_rs2, use_rd;

  always_comb begin
    dec_legal = 1'b0;
    dec_aluop = ALU_AND;
    dec_a     = '0;
    dec_b     = '0;
    dec_store = '0;
    dec_rw    = 1'b0;
    dec_mr    = 1'b0;
    dec_mw    = 1'b0;
    dec_br    = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    use_rd    = 1'b0;
    case (op)
      OP_R: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec_a   = rd1;
        dec_b   = rd2;
        dec_rw  = 1'b1;
        case (func)
          3'b000:  begin dec_legal = 1'b1; dec_aluop = ALU_AND; end
          3'b001:  begin dec_legal = 1'b1; dec_aluop = ALU_ADD; end
          3'b010:  begin dec_legal = 1'b1; dec_aluop = ALU_SUB; end
          default: dec_legal = 1'b0;
        endcase
      end
      OP_ANDI, OP_ADDI, OP_LW: begin
        dec_legal = 1'b1;
        use_rs1   = 1'b1;
        dec_aluop = (op == OP_ANDI) ? ALU_AND : ALU_ADD;
        dec_a     = rd1;
        dec_b     = imm_ext;
        dec_rw    = 1'b1;
        dec_mr    = (op == OP_LW);
      end
      OP_SW: begin
        dec_legal = 1'b1;
        use_rs1   = 1'b1;
        use_rd    = 1'b1;
        dec_aluop = ALU_ADD;
        dec_a     = rd1;
        dec_b     = imm_ext;
        dec_store = rd2;
        dec_mw    = 1'b1;
      end
      OP_BEQ: begin
        dec_legal = 1'b1;
        use_rs1   = 1'b1;
        use_rd    = 1'b1;
        dec_aluop = ALU_SUB;
        dec_a     = rd2;
        dec_b     = rd1;
        dec_br    = 1'b1;
      end
      OP_NOP:  dec_legal = 1'b1;
      default: dec_legal = 1'b0;
    endcase
  end

  // Only a load still sitting in ID/EX can hand a stale value to the next instruction.
  logic hazard;
  assign hazard = if_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                  ((use_rs1 & (rs1 == ex_rd)) |
                   (use_rs2 & (rs2 == ex_rd)) |
                   (use_rd  & (rd  == ex_rd)));

  assign id_stall = ex_hold | (hazard & ~flush);

  always_ff @(posedge clk) begin
    if (reset || flush || (!ex_hold && (hazard || !if_valid))) begin
      ex_valid      <= 1'b0;
      ex_aluop      <= '0;
      ex_a          <= '0;
      ex_b          <= '0;
      ex_store_data <= '0;
      ex_rd         <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_branch     <= 1'b0;
      ex_illegal    <= 1'b0;
    end else if (!ex_hold) begin
      // An illegal instruction is consumed but issues as a flagged bubble.
      ex_valid      <= dec_legal;
      ex_aluop      <= dec_legal ? dec_aluop : '0;
      ex_a          <= dec_legal ? dec_a : '0;
      ex_b          <= dec_legal ? dec_b : '0;
      ex_store_data <= dec_legal ? dec_store : '0;
      ex_rd         <= dec_legal ? rd : '0;
      ex_reg_write  <= dec_legal & dec_rw;
      ex_mem_read   <= dec_legal & dec_mr;
      ex_mem_write  <= dec_legal & dec_mw;
      ex_branch     <= dec_legal & dec_br;
      ex_illegal    <= ~dec_legal;
    end
  end

endmodule
